// File: rtl/traffic_light_pkg.sv
// Shared lamp codes and phase encoding for the N-approach traffic-light controller.
package traffic_light_pkg;

  localparam logic [2:0] LampGreen  = 3'b101;
  localparam logic [2:0] LampYellow = 3'b001;
  localparam logic [2:0] LampRed    = 3'b011;
  localparam logic [2:0] LampOff    = 3'b000;

  typedef enum logic [1:0] {
    PhGreen  = 2'd0,
    PhYellow = 2'd1,
    PhAllRed = 2'd2,
    PhFlash  = 2'd3
  } phase_t;

  // Flashing lamp: the toggle flop starts at 0, which shows yellow first.
  function automatic logic [2:0] flash_lamp(input logic dark);
    return dark ? LampOff : LampYellow;
  endfunction

endpackage

// File: rtl/tl_rr_select.sv
// Round-robin picker: first requester after base (wrapping), falls back to base itself.
module tl_rr_select
  import traffic_light_pkg::*;
#(
  parameter int unsigned N_DIR = 4
) (
  input  logic [N_DIR-1:0]         req,
  input  logic [$clog2(N_DIR)-1:0] base,
  output logic [$clog2(N_DIR)-1:0] grant,
  output logic                     valid
);

  localparam int unsigned IdxW = $clog2(N_DIR);
  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] idx;

  // valid only reflects requesters other than base; grant stays at base when none.
  always_comb begin
    grant = base;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k < N_DIR; k++) begin
      idx = {1'b0, base} + SumW'(k);
      if (idx >= SumW'(N_DIR)) begin
        idx = idx - SumW'(N_DIR);
      end
      if (!valid && req[idx[IdxW-1:0]]) begin
        valid = 1'b1;
        grant = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-approach round-robin traffic-light controller with min/max green and all-red clearance.
// Optional flashing-yellow mode via `define TRAFFIC_LIGHT_FLASH_EN (adds flash_req input).
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int unsigned N_DIR     = 4,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic [N_DIR-1:0]         car,
`ifdef TRAFFIC_LIGHT_FLASH_EN
  input  logic                     flash_req,
`endif
  output logic [3*N_DIR-1:0]       lights,
  output logic [$clog2(N_DIR)-1:0] active_dir,
  output logic [1:0]               phase
);

  localparam int unsigned IdxW = $clog2(N_DIR);

  localparam logic [CNT_W-1:0] MinCnt    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MaxCnt    = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YelLast   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] RedLast   = CNT_W'(ALLRED_T - 1);

  phase_t            phase_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IdxW-1:0]   active_q;
  logic [IdxW-1:0]   next_q;
  logic [IdxW-1:0]   rr_grant;
  logic              other_demand;
  logic              go_yellow;
  logic              flash_on;

`ifdef TRAFFIC_LIGHT_FLASH_EN
  logic              tog_q;
  assign flash_on = flash_req;
`else
  assign flash_on = 1'b0;
`endif

  tl_rr_select #(
    .N_DIR (N_DIR)
  ) u_rr_select (
    .req   (car),
    .base  (active_q),
    .grant (rr_grant),
    .valid (other_demand)
  );

  assign cnt_inc   = (cnt_q == MaxCnt) ? cnt_q : cnt_q + 1'b1;
  // Green may only end once someone else waits; a present own car extends it up to MAX.
  assign go_yellow = (cnt_q >= MinCnt) && other_demand &&
                     (!car[active_q] || (cnt_q >= MaxCnt));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= PhGreen;
      cnt_q    <= '0;
      active_q <= '0;
      next_q   <= '0;
    end else if (flash_on) begin
      if (phase_q != PhFlash) begin
        phase_q <= PhFlash;
        cnt_q   <= '0;
      end
    end else begin
      case (phase_q)
        PhGreen: begin
          if (go_yellow) begin
            phase_q <= PhYellow;
            cnt_q   <= '0;
            next_q  <= rr_grant;
          end else if (tick) begin
            cnt_q <= cnt_inc;
          end
        end
        PhYellow: begin
          if (tick) begin
            if (cnt_q == YelLast) begin
              phase_q <= PhAllRed;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        PhAllRed: begin
          if (tick) begin
            if (cnt_q == RedLast) begin
              phase_q  <= PhGreen;
              cnt_q    <= '0;
              active_q <= next_q;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        // Flash exit, or an illegal encoding: recover through a clearance interval.
        PhFlash: begin
          phase_q <= PhAllRed;
          cnt_q   <= '0;
          next_q  <= rr_grant;
        end
      endcase
    end
  end

`ifdef TRAFFIC_LIGHT_FLASH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
    end else if (flash_req && (phase_q == PhFlash)) begin
      tog_q <= tog_q ^ tick;
    end else begin
      tog_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    lights = {N_DIR{LampRed}};
    for (int unsigned i = 0; i < N_DIR; i++) begin
      case (phase_q)
        PhGreen: begin
          if (IdxW'(i) == active_q) lights[3*i +: 3] = LampGreen;
        end
        PhYellow: begin
          if (IdxW'(i) == active_q) lights[3*i +: 3] = LampYellow;
        end
        PhFlash: begin
`ifdef TRAFFIC_LIGHT_FLASH_EN
          lights[3*i +: 3] = flash_lamp(tog_q);
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign active_dir = active_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and randomized checks of traffic_light_ctrl against a tick-level reference model.
module tb_traffic_light_ctrl;

  localparam int N    = 4;
  localparam int MING = 4;
  localparam int MAXG = 10;
  localparam int YT   = 2;
  localparam int AT   = 1;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            tick;
  logic [N-1:0]    car;
  logic            flash_req;
  logic [3*N-1:0]  lights;
  logic [1:0]      active_dir;
  logic [1:0]      phase;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: phase as 0 green / 1 yellow / 2 all-red / 3 flash.
  int m_ph, m_cnt, m_dir, m_next;
  bit m_tog;

  traffic_light_ctrl #(
    .N_DIR     (N),
    .MIN_GREEN (MING),
    .MAX_GREEN (MAXG),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .car        (car),
`ifdef TRAFFIC_LIGHT_FLASH_EN
    .flash_req  (flash_req),
`endif
    .lights     (lights),
    .active_dir (active_dir),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  function automatic int pick_next(input logic [N-1:0] c, input int from);
    int j;
    pick_next = from;
    for (int k = N; k >= 1; k--) begin
      j = (from + k) % N;
      if (c[j]) pick_next = j;
    end
  endfunction

  function automatic bit others_waiting(input logic [N-1:0] c, input int from);
    others_waiting = 1'b0;
    for (int k = 1; k < N; k++) begin
      if (c[(from + k) % N]) others_waiting = 1'b1;
    end
  endfunction

  function automatic logic [3*N-1:0] model_lights();
    logic [3*N-1:0] l;
    for (int i = 0; i < N; i++) begin
      case (m_ph)
        0:       l[3*i +: 3] = (i == m_dir) ? 3'b101 : 3'b011;
        1:       l[3*i +: 3] = (i == m_dir) ? 3'b001 : 3'b011;
        3:       l[3*i +: 3] = m_tog ? 3'b000 : 3'b001;
        default: l[3*i +: 3] = 3'b011;
      endcase
    end
    return l;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_dir = 0; m_next = 0; m_tog = 0;
  endtask

  task automatic model_step(input logic [N-1:0] c, input logic t, input logic f);
    if (f) begin
      if (m_ph != 3) begin
        m_ph = 3; m_tog = 0;
      end else if (t) begin
        m_tog = !m_tog;
      end
    end else begin
      m_tog = 0;
      case (m_ph)
        0: begin
          if (m_cnt >= MING && others_waiting(c, m_dir) && (!c[m_dir] || m_cnt >= MAXG)) begin
            m_next = pick_next(c, m_dir); m_ph = 1; m_cnt = 0;
          end else if (t && m_cnt < MAXG) begin
            m_cnt++;
          end
        end
        1: if (t) begin
          if (m_cnt == YT - 1) begin m_ph = 2; m_cnt = 0; end else m_cnt++;
        end
        2: if (t) begin
          if (m_cnt == AT - 1) begin m_ph = 0; m_cnt = 0; m_dir = m_next; end else m_cnt++;
        end
        default: begin
          m_ph = 2; m_cnt = 0; m_next = pick_next(c, m_dir);
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".lights"}, 32'(lights), 32'(model_lights()));
    check({tag, ".phase"}, 32'(phase), 32'(m_ph));
    check({tag, ".dir"}, 32'(active_dir), 32'(m_dir));
  endtask

  task automatic step(input logic [N-1:0] c, input logic t, input logic f, input string tag);
    car = c; tick = t; flash_req = f;
    @(posedge clk);
    model_step(c, t, f);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; car = '0; tick = 1'b0; flash_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    check_all("reset");
  endtask

  logic [N-1:0] rc;
  logic         rt, rf;

  initial begin
    // 1: idle intersection holds approach 0 green.
    do_reset();
    check("t1.lights_reset", 32'(lights), 32'h6DD);
    repeat (50) step(4'b0000, 1'b1, 1'b0, "t1");
    check("t1.phase_50", 32'(phase), 32'd0);
    check("t1.dir_50", 32'(active_dir), 32'd0);

    // 2: single request on approach 1.
    do_reset();
    repeat (4) step(4'b0010, 1'b1, 1'b0, "t2");
    check("t2.still_green", 32'(phase), 32'd0);
    step(4'b0010, 1'b1, 1'b0, "t2");
    check("t2.yellow", 32'(phase), 32'd1);
    repeat (2) step(4'b0010, 1'b1, 1'b0, "t2");
    check("t2.allred", 32'(lights), 32'h6DB);
    step(4'b0010, 1'b1, 1'b0, "t2");
    check("t2.dir1", 32'(active_dir), 32'd1);
    check("t2.lamp1", 32'(lights[5:3]), 32'b101);

    // 3: all approaches waiting, forced change at MAX_GREEN.
    do_reset();
    repeat (10) step(4'b1111, 1'b1, 1'b0, "t3");
    check("t3.green_at_10", 32'(phase), 32'd0);
    step(4'b1111, 1'b1, 1'b0, "t3");
    check("t3.yellow_at_11", 32'(phase), 32'd1);
    repeat (3) step(4'b1111, 1'b1, 1'b0, "t3");
    check("t3.order1", 32'(active_dir), 32'd1);
    for (int r = 2; r <= 4; r++) begin
      repeat (14) step(4'b1111, 1'b1, 1'b0, "t3");
      check("t3.order", 32'(active_dir), 32'(r % 4));
    end

    // 4: wrap from approach 3 to 0, latched next_dir ignores yellow-time sensors.
    do_reset();
    repeat (8) step(4'b1000, 1'b1, 1'b0, "t4");
    check("t4.dir3", 32'(active_dir), 32'd3);
    repeat (5) step(4'b0001, 1'b1, 1'b0, "t4");
    check("t4.yellow", 32'(phase), 32'd1);
    repeat (3) step(4'b0100, 1'b1, 1'b0, "t4");
    check("t4.wrap_dir0", 32'(active_dir), 32'd0);
    check("t4.wrap_green", 32'(phase), 32'd0);

    // 5: asynchronous reset during yellow.
    do_reset();
    repeat (5) step(4'b0010, 1'b1, 1'b0, "t5");
    check("t5.yellow", 32'(phase), 32'd1);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("t5.async");
    check("t5.lights", 32'(lights), 32'h6DD);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) step(4'b0100, 1'b1, 1'b0, "t5.after");

`ifdef TRAFFIC_LIGHT_FLASH_EN
    // 6: flashing mode, then resume to the next round-robin requester.
    do_reset();
    step(4'b0100, 1'b1, 1'b1, "t6");
    check("t6.flash_on", 32'(lights), 32'h249);
    repeat (5) step(4'b0100, 1'b1, 1'b1, "t6");
    step(4'b0100, 1'b1, 1'b0, "t6");
    check("t6.allred", 32'(phase), 32'd2);
    step(4'b0100, 1'b1, 1'b0, "t6");
    check("t6.dir2", 32'(active_dir), 32'd2);
`endif

    // Randomized traffic with sparse ticks.
    do_reset();
    rc = '0;
    rf = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) rc = N'($urandom);
      rt = ($urandom_range(0, 3) != 0);
`ifdef TRAFFIC_LIGHT_FLASH_EN
      if ($urandom_range(0, 60) == 0) rf = !rf;
`endif
      step(rc, rt, rf, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised N-approach traffic-light controller. Generalises the two-road sensor-driven controller to N_DIR approaches with round-robin service, configurable phase timing, min/max green enforcement and an all-red clearance interval. One instance per intersection, clocked from the system clock, with a timing-enable pulse (tick) from a shared prescaler.

Parameters:
N_DIR, 4, number of approaches (2..8)
MIN_GREEN, 4, minimum green duration in ticks (>=1)
MAX_GREEN, 10, green duration in ticks after which a waiting approach forces a change (>MIN_GREEN)
YELLOW_T, 2, yellow duration in ticks (>=1)
ALLRED_T, 1, all-red clearance duration in ticks (>=1)
CNT_W, 8, phase counter width; must satisfy 2**CNT_W > MAX_GREEN

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
tick  input  1  one-cycle timing-enable pulse; all phase durations count tick pulses
car  input  N_DIR  vehicle-present sensor per approach, synchronous to clk
lights  output  3*N_DIR  per-approach lamp code, approach i at [3i+2:3i]; GREEN=3'b101, YELLOW=3'b001, RED=3'b011
active_dir  output  $clog2(N_DIR)  approach currently owning the green/yellow phase
phase  output  2  current state encoding: GREEN=0, YELLOW=1, ALLRED=2

Behaviour:
- Reset values: phase=GREEN, active_dir=0, cnt=0, next_dir=0; lights = approach 0 GREEN, all others RED.
- cnt: elapsed ticks in the current phase. Cleared to 0 on every phase change. Otherwise increments on tick, saturating at MAX_GREEN.
- other_demand = OR of car[j] for all j != active_dir.
- GREEN -> YELLOW when cnt >= MIN_GREEN && other_demand && (!car[active_dir] || cnt >= MAX_GREEN). This is evaluated every clk, independent of tick. On this transition next_dir is latched.
- Without other_demand, GREEN holds indefinitely, even if car[active_dir]=0.
- next_dir: first j in order active_dir+1, active_dir+2, ... (mod N_DIR) with car[j]=1. Computed combinationally from the car value in the transition cycle.
- YELLOW -> ALLRED when tick && cnt == YELLOW_T-1.
- ALLRED -> GREEN when tick && cnt == ALLRED_T-1. On this transition active_dir <= next_dir.
- Sensor changes during YELLOW or ALLRED do not alter the latched next_dir.
- lights decode combinationally from the registers:
  - GREEN: active=GREEN, others RED.
  - YELLOW: active=YELLOW, others RED.
  - ALLRED: all RED.
  - Never two non-RED approaches at once.
- Illegal phase encoding (3): lights all RED, next state ALLRED with cnt=0.
- Reset asserted mid-phase: immediate return to reset values. No clearance interval is guaranteed across reset.
- Latency: a sensor edge affects phase at the next clk edge.

Optional Feature:
Macro TRAFFIC_LIGHT_FLASH_EN.
- Defined:
  - Extra input flash_req (1 bit, sync).
  - While flash_req=1, the FSM enters phase FLASH (encoding 3) from any state at the next clk.
  - In FLASH, all lamps alternate YELLOW / 3'b000 (off), toggling on each tick. Starts YELLOW; toggle flop reset to 0.
  - On flash_req deassert, FLASH -> ALLRED with cnt=0, then normal ALLRED exit. next_dir recomputed on FLASH exit.
- Undefined: no flash_req port; encoding 3 treated as illegal as above.

Decomposition:
- Package traffic_light_pkg: lamp code constants GREEN/YELLOW/RED/OFF; phase_t enum (GREEN, YELLOW, ALLRED, FLASH).
- Sub-module tl_rr_select: combinational round-robin picker. Inputs: req[N_DIR], base index. Outputs: grant index, any-valid. Instantiated once for next_dir/other_demand.

Test Plan (defaults N_DIR=4, MIN=4, MAX=10, YELLOW=2, ALLRED=1, tick every cycle):
1. Reset release with car=0 -> approach 0 GREEN, others RED; still GREEN after 50 cycles, active_dir=0.
2. car=4'b0010 from reset -> GREEN for 5 cycles, YELLOW 2, ALLRED 1, then active_dir=1 GREEN, lights[5:3]=3'b101.
3. car=4'b1111 held -> forced change at MAX: each green lasts 11 cycles; service order 0,1,2,3,0.
4. active_dir=3 green, car=4'b0001 -> next_dir wraps to 0; car change to 4'b0100 during YELLOW -> still goes to 0.
5. Assert reset_n low during YELLOW -> lights immediately dir 0 GREEN/others RED, cnt=0.
6. (FLASH_EN) flash_req=1 for 6 cycles -> all approaches alternate 3'b001/3'b000. On release: 1 ALLRED cycle, then green to the next round-robin requester.
